bcd_display_scan: RTL and testbench

//   Time-multiplexed 7-segment driver for a chain of cascaded BCD counter digits.

---
 rtl/bcd_display_scan_pkg.sv | 20 ++
 rtl/bcd_display_scan_if.sv | 26 ++
 rtl/bcd_display_scan_bcd_to_7seg.sv | 27 ++
 rtl/bcd_display_scan.sv | 105 ++++++++++
 tb/tb_bcd_display_scan.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/bcd_display_scan_pkg.sv
// Shared segment encodings for the BCD display scanner.
// All patterns are {g,f,e,d,c,b,a}, active-low.
package bcd_display_scan_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0    = 7'b1000000;
  localparam seg_t SEG_1    = 7'b1111001;
  localparam seg_t SEG_2    = 7'b0100100;
  localparam seg_t SEG_3    = 7'b0110000;
  localparam seg_t SEG_4    = 7'b0011001;
  localparam seg_t SEG_5    = 7'b0010010;
  localparam seg_t SEG_6    = 7'b0000010;
  localparam seg_t SEG_7    = 7'b1111000;
  localparam seg_t SEG_8    = 7'b0000000;
  localparam seg_t SEG_9    = 7'b0010000;
  localparam seg_t SEG_DASH = 7'b0111111;
  localparam seg_t SEG_OFF  = 7'b1111111;

endpackage

// File: rtl/bcd_display_scan_if.sv
// Digit/control inputs and display-side outputs of the scanner.
// The slave side is the scanner; the master side feeds it.
interface bcd_display_scan_if #(
  parameter int NUM_DIGITS = 4
);

  logic                      ENABLE;
  logic [4*NUM_DIGITS-1:0]   D_IN;
  logic [NUM_DIGITS-1:0]     DP_IN;
  logic                      BLANK;
  logic [NUM_DIGITS-1:0]     AN;
  logic [6:0]                SEG;
  logic                      DP;
  logic                      FRAME;

  modport master (
    output ENABLE, D_IN, DP_IN, BLANK,
    input  AN, SEG, DP, FRAME
  );

  modport slave (
    input  ENABLE, D_IN, DP_IN, BLANK,
    output AN, SEG, DP, FRAME
  );

endinterface

// File: rtl/bcd_display_scan_bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment decoder.
// Codes above 9 render as a dash.
module bcd_to_7seg
  import bcd_display_scan_pkg::*;
(
  input  logic [3:0] code,
  output seg_t       seg
);

  always_comb begin
    seg = SEG_DASH;
    case (code)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scan.sv
// Time-multiplexed common-anode driver for a chain of BCD digits,
// with frame snapshot, leading-zero blanking and a per-slot guard cycle.
module bcd_display_scan
  import bcd_display_scan_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_DIV   = 50000,
  parameter int BLANK_LEADING = 1
) (
  input  logic CLK,
  input  logic CLR,
  bcd_display_scan_if.slave bus
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [DW-1:0] LAST_DIV = DW'(REFRESH_DIV - 1);

  logic [DW-1:0]           div;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] snap;
  logic [NUM_DIGITS-1:0]   snap_dp;

  logic [NUM_DIGITS-1:0]   an_q;
  seg_t                    seg_q;
  logic                    dp_q;
  logic                    frame_q;

  logic [NUM_DIGITS-1:0]   lead_blank;
  logic                    hi_zero;
  logic [3:0]              cur_code;
  seg_t                    cur_seg;
  logic                    slot_blank;
  logic                    frame_start;
  logic [NUM_DIGITS-1:0]   an_nxt;
  seg_t                    seg_nxt;
  logic                    dp_nxt;

  // Walk from the top digit down; a digit is blank while everything
  // at or above it is a zero with no decimal point.
  always_comb begin
    lead_blank = '0;
    hi_zero    = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      hi_zero = hi_zero
              && (snap[4*k +: 4] == 4'd0)
              && !snap_dp[k];
      lead_blank[k] = (BLANK_LEADING != 0) && hi_zero;
    end
  end

  assign cur_code = snap[4*idx +: 4];

  bcd_to_7seg u_dec (
    .code (cur_code),
    .seg  (cur_seg)
  );

  always_comb begin
    slot_blank  = lead_blank[idx];
    frame_start = bus.ENABLE && (div == '0) && (idx == '0);
    an_nxt      = '1;
    if ((div != '0) && !slot_blank && !bus.BLANK)
      an_nxt[idx] = 1'b0;
    seg_nxt = slot_blank ? SEG_OFF : cur_seg;
    dp_nxt  = slot_blank ? 1'b1 : ~snap_dp[idx];
  end

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      div     <= '0;
      idx     <= '0;
      snap    <= '0;
      snap_dp <= '0;
      an_q    <= '1;
      seg_q   <= SEG_OFF;
      dp_q    <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      frame_q <= frame_start;
      if (bus.ENABLE) begin
        if (div == LAST_DIV) begin
          div <= '0;
          idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end else begin
          div <= div + 1'b1;
        end
        if (frame_start) begin
          snap    <= bus.D_IN;
          snap_dp <= bus.DP_IN;
        end
        an_q  <= an_nxt;
        seg_q <= seg_nxt;
        dp_q  <= dp_nxt;
      end
    end
  end

  assign bus.AN    = an_q;
  assign bus.SEG   = seg_q;
  assign bus.DP    = dp_q;
  assign bus.FRAME = frame_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Scoreboard bench: a frame-position reference model predicts each edge,
// a negedge monitor pops predictions and compares them to the display pins.
module tb_bcd_display_scan;

  localparam int N  = 4;
  localparam int R  = 4;
  localparam int FL = N * R;

  typedef struct packed {
    logic [N-1:0] an;
    logic [6:0]   seg;
    logic         dp;
    logic         frame;
  } obs_t;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  bcd_display_scan_if #(.NUM_DIGITS(N)) bus ();

  bcd_display_scan #(
    .NUM_DIGITS    (N),
    .REFRESH_DIV   (R),
    .BLANK_LEADING (1)
  ) dut (
    .CLK (clk),
    .CLR (clr),
    .bus (bus.slave)
  );

  obs_t exp_q[$];
  obs_t last_exp;
  int   tests = 0;
  int   fails = 0;

  // Model state: position within the frame and the captured digits.
  int m_pos;
  int m_dig[N];
  bit m_dp[N];

  function automatic logic [6:0] seg_of(int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  task automatic model_edge();
    obs_t e;
    int   slot;
    int   ph;
    bit   blank;
    if (!clr) begin
      e = '{an: '1, seg: 7'h7F, dp: 1'b1, frame: 1'b0};
      m_pos = 0;
      for (int j = 0; j < N; j++) begin
        m_dig[j] = 0;
        m_dp[j]  = 1'b0;
      end
    end else if (!bus.ENABLE) begin
      e = last_exp;
      e.frame = 1'b0;
    end else begin
      slot  = m_pos / R;
      ph    = m_pos % R;
      blank = 1'b0;
      if (slot > 0) begin
        blank = 1'b1;
        for (int j = slot; j < N; j++)
          if (m_dig[j] != 0 || m_dp[j]) blank = 1'b0;
      end
      e.seg = blank ? 7'h7F : seg_of(m_dig[slot]);
      e.dp  = blank ? 1'b1 : !m_dp[slot];
      e.an  = '1;
      if (ph != 0 && !blank && !bus.BLANK)
        e.an = ~(N'(1) << slot);
      e.frame = (m_pos == 0);
      if (m_pos == 0) begin
        for (int j = 0; j < N; j++) begin
          m_dig[j] = int'(bus.D_IN[4*j +: 4]);
          m_dp[j]  = bus.DP_IN[j];
        end
      end
      m_pos = (m_pos + 1) % FL;
    end
    last_exp = e;
    exp_q.push_back(e);
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      model_edge();
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    obs_t e;
    obs_t a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {bus.AN, bus.SEG, bus.DP, bus.FRAME};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL scan @%0t: got an=%h seg=%b dp=%b frame=%b, want an=%h seg=%b dp=%b frame=%b",
                 $time, a.an, a.seg, a.dp, a.frame,
                 e.an, e.seg, e.dp, e.frame);
      end
    end
  end

  logic [4*N-1:0] rd;
  int nd;

  initial begin
    bus.ENABLE = 1'b0;
    bus.D_IN   = '0;
    bus.DP_IN  = '0;
    bus.BLANK  = 1'b0;
    clr = 1'b0;
    tick(3);

    clr = 1'b1;
    bus.ENABLE = 1'b1;
    bus.D_IN = 16'h1234;
    tick(2 * FL);

    bus.D_IN = 16'h0050;
    tick(2 * FL);
    bus.D_IN = 16'h0000;
    tick(2 * FL);
    bus.DP_IN = 4'b0100;
    tick(2 * FL);
    bus.DP_IN = 4'b0000;

    bus.D_IN = 16'h1234;
    tick(FL + R);
    bus.D_IN = 16'h9876;
    tick(FL - R + FL);

    tick(2);
    bus.ENABLE = 1'b0;
    tick(10);
    bus.ENABLE = 1'b1;
    tick(20);

    bus.D_IN = 16'h12C4;
    tick(2 * FL);

    bus.BLANK = 1'b1;
    tick(20);
    bus.BLANK = 1'b0;
    tick(10);

    tick((FL - m_pos) % FL);
    tick(2 * R + 1);
    clr = 1'b0;
    tick(1);
    clr = 1'b1;
    tick(20);

    repeat (800) begin
      if ($urandom_range(0, 4) == 0) begin
        rd = '0;
        nd = $urandom_range(0, N);
        for (int j = 0; j < nd; j++)
          rd[4*j +: 4] = ($urandom_range(0, 9) == 0)
                       ? 4'($urandom_range(10, 15))
                       : 4'($urandom_range(0, 9));
        bus.D_IN = rd;
      end
      if ($urandom_range(0, 9) == 0)
        bus.DP_IN = ($urandom_range(0, 1) == 0) ? '0 : N'($urandom);
      bus.ENABLE = ($urandom_range(0, 6) != 0);
      bus.BLANK  = ($urandom_range(0, 14) == 0);
      clr        = ($urandom_range(0, 119) != 0);
      tick(1);
    end

    clr = 1'b1;
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d predictions left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
